// File: rtl/gpio_pkg.sv
// Shared register map, register enumeration and byte-lane helper for the GPIO interrupt block.
package gpio_pkg;

  localparam logic [2:0] GPIO_REG_IN    = 3'd0;
  localparam logic [2:0] GPIO_REG_OUT   = 3'd1;
  localparam logic [2:0] GPIO_REG_OE    = 3'd2;
  localparam logic [2:0] GPIO_REG_IOSEL = 3'd3;
  localparam logic [2:0] GPIO_REG_INTE  = 3'd4;
  localparam logic [2:0] GPIO_REG_PTRIG = 3'd5;
  localparam logic [2:0] GPIO_REG_INTS  = 3'd6;
  localparam logic [2:0] GPIO_REG_CTRL  = 3'd7;

  localparam int CTRL_GIE_BIT = 0;

  typedef enum logic [2:0] {
    REG_IN    = GPIO_REG_IN,
    REG_OUT   = GPIO_REG_OUT,
    REG_OE    = GPIO_REG_OE,
    REG_IOSEL = GPIO_REG_IOSEL,
    REG_INTE  = GPIO_REG_INTE,
    REG_PTRIG = GPIO_REG_PTRIG,
    REG_INTS  = GPIO_REG_INTS,
    REG_CTRL  = GPIO_REG_CTRL
  } gpio_reg_e;

  // Expands the four byte enables into a 32-bit bit mask; callers slice it to their width.
  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    logic [31:0] m;
    m = 32'h0000_0000;
    for (int k = 0; k < 4; k++) begin
      m[8*k +: 8] = {8{sel[k]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Pad input synchroniser with a one-cycle history flop and per-pin rising/falling edge select.
module gpio_sync_edge
#(
  parameter int W           = 24,
  parameter int SYNC_STAGES = 2
)
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  input  logic [W-1:0] ptrig,
  output logic [W-1:0] sync,
  output logic [W-1:0] ev
);

  logic [SYNC_STAGES-1:0][W-1:0] chain_r;
  logic [W-1:0]                  prev_r;

  // Metastability chain; the last stage is the usable synchronised value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain_r <= '0;
      prev_r  <= '0;
    end else begin
      chain_r <= {chain_r[SYNC_STAGES-2:0], din};
      prev_r  <= chain_r[SYNC_STAGES-1];
    end
  end

  assign sync = chain_r[SYNC_STAGES-1];
  assign ev   = (ptrig & sync & ~prev_r) | (~ptrig & ~sync & prev_r);

endmodule

// File: rtl/gpio_irq_top.sv
// Wishbone GPIO peripheral: pad output/enable, shared-pin select, edge interrupts with W1C status.
module gpio_irq_top
  import gpio_pkg::*;
#(
  parameter int NO_OF_GPIO_PINS   = 24,
  parameter int NO_OF_SHARED_PINS = 13,
  parameter int SYNC_STAGES       = 2,
  parameter int aw                = 5
)
(
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_ni,
  input  logic                         wb_cyc_i,
  input  logic                         wb_stb_i,
  input  logic                         wb_we_i,
  input  logic [aw-1:0]                wb_adr_i,
  input  logic [31:0]                  wb_dat_i,
  input  logic [3:0]                   wb_sel_i,
  output logic [31:0]                  wb_dat_o,
  output logic                         wb_ack_o,
  output logic                         wb_err_o,
  output logic                         wb_inta_o,
  input  logic [NO_OF_GPIO_PINS-1:0]   i_gpio,
  output logic [NO_OF_GPIO_PINS-1:0]   o_gpio,
  output logic [NO_OF_GPIO_PINS-1:0]   en_gpio,
  output logic [NO_OF_SHARED_PINS-1:0] io_sel
);

  localparam int NG = NO_OF_GPIO_PINS;
  localparam int NS = NO_OF_SHARED_PINS;

  logic [NG-1:0] out_r, oe_r, inte_r, ptrig_r, ints_r;
  logic [NS-1:0] iosel_r;
  logic          gie_r, ack_r, inta_r;
  logic [31:0]   dat_r;

  logic [NG-1:0] sync_s, ev_s, w1c_s, gm_s;
  logic [NS-1:0] sm_s;
  logic [31:0]   wmask_s, rdata_s;
  logic          acc_s, wr_s, unused_s;
  gpio_reg_e     reg_s;

  assign reg_s   = gpio_reg_e'(wb_adr_i[4:2]);
  assign acc_s   = wb_cyc_i & wb_stb_i & ~ack_r;
  assign wr_s    = acc_s & wb_we_i;
  assign wmask_s = lane_mask(wb_sel_i);
  assign gm_s    = wmask_s[NG-1:0];
  assign sm_s    = wmask_s[NS-1:0];

  gpio_sync_edge #(.W(NG), .SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .din   (i_gpio),
    .ptrig (ptrig_r),
    .sync  (sync_s),
    .ev    (ev_s)
  );

  // W1C bits honour the byte lanes like any other write.
  always_comb begin
    w1c_s = '0;
    if (wr_s && (reg_s == REG_INTS)) begin
      w1c_s = wb_dat_i[NG-1:0] & gm_s;
    end else begin
      w1c_s = '0;
    end
  end

  always_comb begin
    rdata_s = 32'h0000_0000;
    case (reg_s)
      REG_IN:    rdata_s[NG-1:0]       = sync_s;
      REG_OUT:   rdata_s[NG-1:0]       = out_r;
      REG_OE:    rdata_s[NG-1:0]       = oe_r;
      REG_IOSEL: rdata_s[NS-1:0]       = iosel_r;
      REG_INTE:  rdata_s[NG-1:0]       = inte_r;
      REG_PTRIG: rdata_s[NG-1:0]       = ptrig_r;
      REG_INTS:  rdata_s[NG-1:0]       = ints_r;
      REG_CTRL:  rdata_s[CTRL_GIE_BIT] = gie_r;
      default:   rdata_s               = 32'h0000_0000;
    endcase
  end

  // Register file; a same-cycle event beats a W1C because the set term is ORed in last.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      out_r   <= '0;
      oe_r    <= '0;
      iosel_r <= '0;
      inte_r  <= '0;
      ptrig_r <= '0;
      ints_r  <= '0;
      gie_r   <= 1'b0;
    end else begin
      ints_r <= (ints_r & ~w1c_s) | (ev_s & inte_r);
      if (wr_s) begin
        case (reg_s)
          REG_OUT:   out_r   <= (out_r   & ~gm_s) | (wb_dat_i[NG-1:0] & gm_s);
          REG_OE:    oe_r    <= (oe_r    & ~gm_s) | (wb_dat_i[NG-1:0] & gm_s);
          REG_IOSEL: iosel_r <= (iosel_r & ~sm_s) | (wb_dat_i[NS-1:0] & sm_s);
          REG_INTE:  inte_r  <= (inte_r  & ~gm_s) | (wb_dat_i[NG-1:0] & gm_s);
          REG_PTRIG: ptrig_r <= (ptrig_r & ~gm_s) | (wb_dat_i[NG-1:0] & gm_s);
          REG_CTRL: begin
            if (wb_sel_i[0]) begin
              gie_r <= wb_dat_i[CTRL_GIE_BIT];
            end else begin
              gie_r <= gie_r;
            end
          end
          default: begin
            out_r <= out_r;
          end
        endcase
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      ack_r  <= 1'b0;
      dat_r  <= 32'h0000_0000;
      inta_r <= 1'b0;
    end else begin
      ack_r  <= acc_s;
      inta_r <= gie_r & (|(ints_r & inte_r));
      if (acc_s) begin
        dat_r <= rdata_s;
      end else begin
        dat_r <= dat_r;
      end
    end
  end

  assign wb_dat_o  = dat_r;
  assign wb_ack_o  = ack_r;
  assign wb_err_o  = 1'b0;
  assign wb_inta_o = inta_r;
  assign o_gpio    = out_r;
  assign en_gpio   = oe_r;
  assign io_sel    = iosel_r;

  assign unused_s = ^{wb_adr_i, wb_dat_i, wmask_s};

endmodule

// File: tb/tb_gpio_irq_top.sv
// Bench for gpio_irq_top: two instances (default and 32/8/3) on one bus, directed tables plus a random scoreboard.
module tb_gpio_irq_top;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, cyc, stb, we;
  logic [4:0]  adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic [31:0] gpio;

  logic [31:0] dat_o0, dat_o1;
  logic        ack0, ack1, err0, err1, inta0, inta1;
  logic [23:0] o_gpio0, en_gpio0;
  logic [12:0] io_sel0;
  logic [31:0] o_gpio1, en_gpio1;
  logic [7:0]  io_sel1;

  int n_chk  = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  gpio_irq_top dut0 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel), .wb_dat_o(dat_o0), .wb_ack_o(ack0),
    .wb_err_o(err0), .wb_inta_o(inta0), .i_gpio(gpio[23:0]), .o_gpio(o_gpio0),
    .en_gpio(en_gpio0), .io_sel(io_sel0)
  );

  gpio_irq_top #(.NO_OF_GPIO_PINS(32), .NO_OF_SHARED_PINS(8), .SYNC_STAGES(3), .aw(5)) dut1 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel), .wb_dat_o(dat_o1), .wb_ack_o(ack1),
    .wb_err_o(err1), .wb_inta_o(inta1), .i_gpio(gpio), .o_gpio(o_gpio1),
    .en_gpio(en_gpio1), .io_sel(io_sel1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic logic [31:0] gmask(input int i);
    return (i == 0) ? 32'h00FF_FFFF : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] smask(input int i);
    return (i == 0) ? 32'h0000_1FFF : 32'h0000_00FF;
  endfunction
  function automatic int sstg(input int i);
    return (i == 0) ? 2 : 3;
  endfunction
  function automatic logic [31:0] lanes(input logic [3:0] s);
    logic [31:0] m;
    m = 32'h0;
    for (int k = 0; k < 4; k++) if (s[k]) m = m | (32'h0000_00FF << (8 * k));
    return m;
  endfunction

  logic [31:0] m_out[2], m_oe[2], m_iosel[2], m_inte[2], m_ptrig[2], m_ints[2], m_dat[2];
  logic        m_gie[2], m_inta[2];
  logic        m_ack;
  logic [31:0] hist[6];   // hist[j] = pad value sampled j+1 clock edges ago
  logic        m_acc;
  assign m_acc = cyc & stb & ~m_ack;

  function automatic logic [31:0] m_ev(input int i);
    logic [31:0] cur, old;
    cur = hist[sstg(i)-1] & gmask(i);
    old = hist[sstg(i)]   & gmask(i);
    return (m_ptrig[i] & cur & ~old) | (~m_ptrig[i] & ~cur & old);
  endfunction
  function automatic logic [31:0] m_w1c(input int i);
    return (m_acc && we && adr[4:2] == 3'd6) ? (dat & lanes(sel) & gmask(i)) : 32'h0;
  endfunction
  function automatic logic [31:0] m_wr(input logic [31:0] old, input logic [31:0] msk);
    return ((old & ~lanes(sel)) | (dat & lanes(sel))) & msk;
  endfunction
  function automatic logic [31:0] m_rd(input int i, input logic [2:0] a);
    case (a)
      3'd0:    return hist[sstg(i)-1] & gmask(i);
      3'd1:    return m_out[i];
      3'd2:    return m_oe[i];
      3'd3:    return m_iosel[i];
      3'd4:    return m_inte[i];
      3'd5:    return m_ptrig[i];
      3'd6:    return m_ints[i];
      default: return {31'h0, m_gie[i]};
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ack <= 1'b0;
      for (int j = 0; j < 6; j++) hist[j] <= 32'h0;
      for (int i = 0; i < 2; i++) begin
        m_out[i] <= 32'h0; m_oe[i] <= 32'h0; m_iosel[i] <= 32'h0; m_inte[i] <= 32'h0;
        m_ptrig[i] <= 32'h0; m_ints[i] <= 32'h0; m_dat[i] <= 32'h0;
        m_gie[i] <= 1'b0; m_inta[i] <= 1'b0;
      end
    end else begin
      m_ack <= m_acc;
      hist[0] <= gpio;
      for (int j = 1; j < 6; j++) hist[j] <= hist[j-1];
      for (int i = 0; i < 2; i++) begin
        m_ints[i] <= (m_ints[i] & ~m_w1c(i)) | (m_ev(i) & m_inte[i]);
        m_inta[i] <= m_gie[i] & (|(m_ints[i] & m_inte[i]));
        if (m_acc) m_dat[i] <= m_rd(i, adr[4:2]);
        if (m_acc && we) begin
          case (adr[4:2])
            3'd1:    m_out[i]   <= m_wr(m_out[i],   gmask(i));
            3'd2:    m_oe[i]    <= m_wr(m_oe[i],    gmask(i));
            3'd3:    m_iosel[i] <= m_wr(m_iosel[i], smask(i));
            3'd4:    m_inte[i]  <= m_wr(m_inte[i],  gmask(i));
            3'd5:    m_ptrig[i] <= m_wr(m_ptrig[i], gmask(i));
            3'd7:    if (sel[0]) m_gie[i] <= dat[0];
            default: ;
          endcase
        end
      end
    end
  end

  // Scoreboard: compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("sb_ack0",   32'(ack0),     32'(m_ack));
      check("sb_ack1",   32'(ack1),     32'(m_ack));
      check("sb_dat0",   dat_o0,        m_dat[0]);
      check("sb_dat1",   dat_o1,        m_dat[1]);
      check("sb_inta0",  32'(inta0),    32'(m_inta[0]));
      check("sb_inta1",  32'(inta1),    32'(m_inta[1]));
      check("sb_out0",   32'(o_gpio0),  m_out[0]);
      check("sb_out1",   o_gpio1,       m_out[1]);
      check("sb_oe0",    32'(en_gpio0), m_oe[0]);
      check("sb_oe1",    en_gpio1,      m_oe[1]);
      check("sb_iosel0", 32'(io_sel0),  m_iosel[0]);
      check("sb_iosel1", 32'(io_sel1),  m_iosel[1]);
      check("sb_err",    32'({err1, err0}), 32'h0);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic bus(input logic w, input logic [2:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rd0, output logic [31:0] rd1);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = {a, 2'b00}; dat = d; sel = s;
    @(posedge clk); #1;
    check("bus_ack", 32'(ack0), 32'h1);
    rd0 = dat_o0;
    rd1 = dat_o1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check("bus_ack_pulse", 32'(ack0), 32'h0);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[22];
  logic [31:0] r0, r1;
  int acks;

  initial begin
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 5'h0; dat = 32'h0; sel = 4'h0; gpio = 32'h0;
    for (int n = 0; n < 8; n++) tbl[n] = '{1'b0, 3'(n), 32'h0, 4'hF, 1'b1, 32'h0};
    tbl[8]  = '{1'b1, 3'd1, 32'h00A5_5A3C, 4'b0101, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 3'd1, 32'h0,         4'hF,    1'b1, 32'h00A5_003C};
    tbl[10] = '{1'b1, 3'd1, 32'h00A5_5A3C, 4'b1111, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 3'd1, 32'h0,         4'hF,    1'b1, 32'h00A5_5A3C};
    tbl[12] = '{1'b1, 3'd1, 32'hFFFF_FFFF, 4'b0000, 1'b0, 32'h0};
    tbl[13] = '{1'b0, 3'd1, 32'h0,         4'hF,    1'b1, 32'h00A5_5A3C};
    tbl[14] = '{1'b1, 3'd3, 32'hFFFF_FFFF, 4'hF,    1'b0, 32'h0};
    tbl[15] = '{1'b0, 3'd3, 32'h0,         4'hF,    1'b1, 32'h0000_1FFF};
    tbl[16] = '{1'b1, 3'd0, 32'hFFFF_FFFF, 4'hF,    1'b0, 32'h0};
    tbl[17] = '{1'b0, 3'd0, 32'h0,         4'hF,    1'b1, 32'h0};
    tbl[18] = '{1'b1, 3'd7, 32'hFFFF_FFFF, 4'hF,    1'b0, 32'h0};
    tbl[19] = '{1'b0, 3'd7, 32'h0,         4'hF,    1'b1, 32'h0000_0001};
    tbl[20] = '{1'b1, 3'd2, 32'h1234_FF56, 4'b0010, 1'b0, 32'h0};
    tbl[21] = '{1'b0, 3'd2, 32'h0,         4'hF,    1'b1, 32'h0000_FF00};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    #1;
    check("rst_inta", 32'(inta0), 32'h0);
    check("rst_out",  32'(o_gpio0), 32'h0);

    // Reset readback, byte lanes, RO/unused-bit writes.
    for (int n = 0; n < 22; n++) begin
      bus(tbl[n].we, tbl[n].adr, tbl[n].dat, tbl[n].sel, r0, r1);
      if (tbl[n].chk) check($sformatf("tbl%0d", n), r0, tbl[n].exp);
    end
    check("pin_out",   32'(o_gpio0),  32'h00A5_5A3C);
    check("pin_oe",    32'(en_gpio0), 32'h0000_FF00);
    check("pin_iosel", 32'(io_sel0),  32'h0000_1FFF);
    bus(1'b1, 3'd7, 32'h0, 4'hF, r0, r1);

    // Rising edge on pin 3, then W1C.
    bus(1'b1, 3'd4, 32'h8, 4'hF, r0, r1);
    bus(1'b1, 3'd5, 32'h8, 4'hF, r0, r1);
    bus(1'b1, 3'd7, 32'h1, 4'hF, r0, r1);
    @(negedge clk); gpio[3] = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("inta_early", 32'(inta0), 32'h0);
    @(posedge clk); #1;
    check("inta_rise", 32'(inta0), 32'h1);
    bus(1'b0, 3'd6, 32'h0, 4'hF, r0, r1);
    check("ints_set", r0, 32'h8);
    bus(1'b1, 3'd6, 32'h8, 4'hF, r0, r1);
    check("inta_clr", 32'(inta0), 32'h0);
    bus(1'b0, 3'd6, 32'h0, 4'hF, r0, r1);
    check("ints_clr", r0, 32'h0);

    // Falling edge on pin 5 colliding with a W1C of the same bit.
    bus(1'b1, 3'd4, 32'h28, 4'hF, r0, r1);
    @(negedge clk); gpio[5] = 1'b1;
    repeat (6) @(posedge clk);
    bus(1'b0, 3'd6, 32'h0, 4'hF, r0, r1);
    check("rise_ignored", r0, 32'h0);
    @(negedge clk); gpio[5] = 1'b0;
    repeat (2) @(posedge clk);
    bus(1'b1, 3'd6, 32'h20, 4'hF, r0, r1);
    bus(1'b0, 3'd6, 32'h0, 4'hF, r0, r1);
    check("set_wins", r0, 32'h20);
    check("inta_fall", 32'(inta0), 32'h1);
    bus(1'b1, 3'd4, 32'h0, 4'hF, r0, r1);
    check("inta_inte0", 32'(inta0), 32'h0);
    bus(1'b0, 3'd6, 32'h0, 4'hF, r0, r1);
    check("ints_kept", r0, 32'h20);
    bus(1'b1, 3'd6, 32'h20, 4'hF, r0, r1);
    bus(1'b0, 3'd6, 32'h0, 4'hF, r0, r1);
    check("ints_clr5", r0, 32'h0);

    // Back-to-back requests: ack every second cycle.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 5'h0;
    acks = 0;
    for (int j = 0; j < 6; j++) begin
      @(posedge clk); #1;
      check($sformatf("b2b_ack%0d", j), 32'(ack0), (j % 2 == 0) ? 32'h1 : 32'h0);
      if (ack0) acks++;
    end
    @(negedge clk); cyc = 1'b0; stb = 1'b0;
    check("b2b_count", 32'(acks), 32'h3);

    // Reset during a pending write drops it.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 5'h08; dat = 32'hFFFF_FFFF; sel = 4'hF; rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_ack", 32'(ack0), 32'h0);
    check("rst_oe",  32'(en_gpio0), 32'h0);
    @(negedge clk); cyc = 1'b0; stb = 1'b0; we = 1'b0; rst_n = 1'b1;
    bus(1'b0, 3'd2, 32'h0, 4'hF, r0, r1);
    check("rst_oe_rd", r0, 32'h0);

    // Wide instance: full 32-bit OUT, 8-bit io_sel, four-cycle edge latency.
    bus(1'b1, 3'd1, 32'hDEAD_BEEF, 4'hF, r0, r1);
    bus(1'b0, 3'd1, 32'h0, 4'hF, r0, r1);
    check("w_out1", r1, 32'hDEAD_BEEF);
    check("w_out0", r0, 32'h00AD_BEEF);
    bus(1'b1, 3'd3, 32'hFFFF_FFFF, 4'hF, r0, r1);
    bus(1'b0, 3'd3, 32'h0, 4'hF, r0, r1);
    check("w_iosel_rd", r1, 32'h0000_00FF);
    check("w_iosel",    32'(io_sel1), 32'h0000_00FF);
    bus(1'b1, 3'd4, 32'h8000_0000, 4'hF, r0, r1);
    bus(1'b1, 3'd5, 32'h8000_0000, 4'hF, r0, r1);
    bus(1'b1, 3'd7, 32'h1, 4'hF, r0, r1);
    @(negedge clk); gpio[31] = 1'b1;
    repeat (4) @(posedge clk); #1;
    check("w_inta_early", 32'(inta1), 32'h0);
    @(posedge clk); #1;
    check("w_inta_rise", 32'(inta1), 32'h1);
    check("w_inta_narrow", 32'(inta0), 32'h0);

    // Random traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 299) != 0);
      cyc   = ($urandom_range(0, 3) != 0);
      stb   = ($urandom_range(0, 3) != 0);
      we    = 1'($urandom_range(0, 1));
      adr   = 5'($urandom_range(0, 31));
      dat   = $urandom;
      sel   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) gpio = gpio ^ (32'h1 << $urandom_range(0, 31));
    end
    @(negedge clk);
    rst_n = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (4) @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
